// File: rtl/mage_hwlp_sequencer.sv
// Hardware-loop sequencer: steps an N_LP-deep loop nest as an odometer (loop 0 innermost)
// and broadcasts the current IV vector every II cycles, honouring stalls.
module mage_hwlp_sequencer #(
    parameter int unsigned N_LP       = 4,
    parameter int unsigned NBIT_LP_IV = 8,
    parameter int unsigned NBIT_II    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(N_LP)-1:0]      cfg_lp_idx_i,
    input  logic [3*NBIT_LP_IV-1:0]      cfg_vars_i,
    input  logic [$clog2(N_LP):0]        cfg_n_lp_i,
    input  logic [NBIT_II-1:0]           cfg_ii_i,
    input  logic                         start_i,
    input  logic                         stall_i,
    output logic [N_LP*NBIT_LP_IV-1:0]   ivs_o,
    output logic                         iv_valid_o,
    output logic                         last_o,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int unsigned W    = NBIT_LP_IV;
    localparam int unsigned NLPW = $clog2(N_LP) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [W-1:0]        cfg_iv_q  [N_LP];
    logic [W-1:0]        cfg_fv_q  [N_LP];
    logic [W-1:0]        cfg_inc_q [N_LP];
    logic [W-1:0]        iv_q [N_LP];
    logic [W-1:0]        iv_d [N_LP];
    logic [NLPW-1:0]     n_lp_q, n_lp_d;
    logic [NBIT_II-1:0]  ii_q, ii_d;
    logic [NBIT_II-1:0]  ii_cnt_q, ii_cnt_d;

    logic [NLPW-1:0]     n_lp_sel;
    logic [NBIT_II-1:0]  ii_sel;
    logic                empty;
    logic [N_LP-1:0]     active;
    logic [N_LP-1:0]     wrap;
    logic [W:0]          nxt [N_LP];
    logic                last_all;
    logic                valid;
    logic                carry;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < N_LP; k++) begin
                cfg_iv_q[k]  <= '0;
                cfg_fv_q[k]  <= '0;
                cfg_inc_q[k] <= '0;
            end
        end else if (cfg_we_i && state_q == S_IDLE && 32'(cfg_lp_idx_i) < N_LP) begin
            cfg_iv_q[cfg_lp_idx_i]  <= cfg_vars_i[3*W-1:2*W];
            cfg_fv_q[cfg_lp_idx_i]  <= cfg_vars_i[2*W-1:W];
            cfg_inc_q[cfg_lp_idx_i] <= cfg_vars_i[W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            n_lp_q   <= '0;
            ii_q     <= '0;
            ii_cnt_q <= '0;
            for (int unsigned k = 0; k < N_LP; k++) iv_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            n_lp_q   <= n_lp_d;
            ii_q     <= ii_d;
            ii_cnt_q <= ii_cnt_d;
            for (int unsigned k = 0; k < N_LP; k++) iv_q[k] <= iv_d[k];
        end
    end

    // Per-loop step arithmetic is one bit wider than the IVs so iv+inc never wraps.
    always_comb begin
        n_lp_sel = (cfg_n_lp_i > NLPW'(N_LP)) ? NLPW'(N_LP) : cfg_n_lp_i;
        ii_sel   = (cfg_ii_i == '0) ? NBIT_II'(1) : cfg_ii_i;
        empty    = (n_lp_sel == '0);
        last_all = 1'b1;
        for (int unsigned k = 0; k < N_LP; k++) begin
            if (NLPW'(k) < n_lp_sel && cfg_iv_q[k] >= cfg_fv_q[k]) empty = 1'b1;
            active[k] = (NLPW'(k) < n_lp_q);
            nxt[k]    = {1'b0, iv_q[k]} +
                        ((cfg_inc_q[k] == '0) ? (W+1)'(1) : {1'b0, cfg_inc_q[k]});
            wrap[k]   = (nxt[k] >= {1'b0, cfg_fv_q[k]});
            if (active[k] && !wrap[k]) last_all = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        n_lp_d   = n_lp_q;
        ii_d     = ii_q;
        ii_cnt_d = ii_cnt_q;
        iv_d     = iv_q;
        valid    = 1'b0;
        carry    = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    n_lp_d   = n_lp_sel;
                    ii_d     = ii_sel;
                    ii_cnt_d = '0;
                    for (int unsigned k = 0; k < N_LP; k++) iv_d[k] = cfg_iv_q[k];
                    state_d  = empty ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                valid = (ii_cnt_q == '0) && !stall_i;
                if (!stall_i)
                    ii_cnt_d = (ii_cnt_q == ii_q - NBIT_II'(1)) ? '0 : ii_cnt_q + NBIT_II'(1);
                if (valid) begin
                    if (last_all) begin
                        state_d = S_DONE;
                    end else begin
                        for (int unsigned k = 0; k < N_LP; k++) begin
                            if (active[k] && carry) begin
                                if (wrap[k]) begin
                                    iv_d[k] = cfg_iv_q[k];
                                end else begin
                                    iv_d[k] = nxt[k][W-1:0];
                                    carry   = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned k = 0; k < N_LP; k++) ivs_o[k*W +: W] = iv_q[k];
        iv_valid_o = valid;
        last_o     = valid && last_all;
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
    end

endmodule
